// File: rtl/bp_pkg.sv
// Shared definitions for the branch target predictor.
//   - SNT/WNT/WT/ST : 2-bit direction counter states
//   - ctr_inc/ctr_dec : saturating counter steps
//   - bp_index/bp_tag : split a PC into table index and tag for a given
//     index width. The PC is passed zero-extended to MAX_ADDR_W and the
//     caller truncates the result to its own width.
package bp_pkg;

  localparam int MAX_ADDR_W  = 64;
  localparam int MAX_INDEX_W = 8;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Index = pc[index_w+1:2]; the byte offset pc[1:0] never takes part.
  function automatic logic [MAX_INDEX_W-1:0] bp_index(input logic [MAX_ADDR_W-1:0] pc,
                                                      input int unsigned index_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << index_w) - MAX_ADDR_W'(1);
    return MAX_INDEX_W'((pc >> 2) & mask);
  endfunction

  // Tag = everything above the index bits.
  function automatic logic [MAX_ADDR_W-1:0] bp_tag(input logic [MAX_ADDR_W-1:0] pc,
                                                   input int unsigned index_w);
    return pc >> (index_w + 2);
  endfunction

endpackage

// File: rtl/sat_perf_counter.sv
// Saturating event counter.
//   clk   : clock
//   reset : synchronous active-high clear
//   en    : count one event this cycle
//   count : current value, holds at all-ones
module sat_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// IF gets a same-cycle prediction for if_pc; ID trains the table when a
// branch or jump resolves.
//   clk, reset        : clock, synchronous active-high reset
//   if_pc             : PC being fetched
//   pred_taken/target : prediction for if_pc (target 0 when not taken)
//   upd_*             : resolved branch/jump from ID
//   mispredict        : combinational, upd_valid && pred != actual
//   lookup_count      : saturating count of lookup hits
//   mispredict_count  : saturating count of mispredict cycles
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int ENTRIES    = 16,
  parameter int CNT_W      = 16,
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_is_jump,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  output logic              mispredict,
  output logic [CNT_W-1:0]  lookup_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  // Flattened views of the per-entry registers for the read muxes.
  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_arr    [ENTRIES];
  logic [ADDR_W-1:0]  target_arr [ENTRIES];
  logic [1:0]         ctr_arr    [ENTRIES];

  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;

  assign if_idx  = INDEX_W'(bp_index(MAX_ADDR_W'(if_pc), INDEX_W));
  assign if_tag  = TAG_W'(bp_tag(MAX_ADDR_W'(if_pc), INDEX_W));
  assign upd_idx = INDEX_W'(bp_index(MAX_ADDR_W'(upd_pc), INDEX_W));
  assign upd_tag = TAG_W'(bp_tag(MAX_ADDR_W'(upd_pc), INDEX_W));

  // ---------------- lookup (combinational, no bypass of same-cycle update)
  logic lookup_hit;

  assign lookup_hit  = valid_vec[if_idx] && (tag_arr[if_idx] == if_tag);
  assign pred_taken  = PREDICT_EN && lookup_hit && ctr_arr[if_idx][1];
  assign pred_target = pred_taken ? target_arr[if_idx] : '0;

  // ---------------- update decode
  logic       upd_hit;
  logic       ctr_we;
  logic       target_we;
  logic [1:0] ctr_next;

  assign upd_hit = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);

  // Counter/valid are touched on any hit, or on a taken miss (allocation).
  assign ctr_we = upd_valid && (upd_hit || upd_taken);
  // Target (and tag) are written for taken outcomes and for jumps that hit;
  // a not-taken hit keeps the old target.
  assign target_we = upd_valid && (upd_taken || (upd_hit && upd_is_jump));

  always_comb begin
    ctr_next = WT;
    if (upd_hit) begin
      if (upd_is_jump) begin
        ctr_next = ST;
      end else if (upd_taken) begin
        ctr_next = ctr_inc(ctr_arr[upd_idx]);
      end else begin
        ctr_next = ctr_dec(ctr_arr[upd_idx]);
      end
    end else begin
      ctr_next = upd_is_jump ? ST : WT;
    end
  end

  // ---------------- table storage, one register set per entry
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_reg;
      logic [1:0]        ctr_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic [ADDR_W-1:0] target_reg;
      logic              sel;

      assign sel = (upd_idx == INDEX_W'(gi));

      // Reset wins over a same-cycle update, so that update is discarded.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          ctr_reg   <= SNT;
        end else if (ctr_we && sel) begin
          valid_reg <= 1'b1;
          ctr_reg   <= ctr_next;
        end
      end

      // Tag/target need no clearing: valid gates every use of them.
      always_ff @(posedge clk) begin
        if (!reset && target_we && sel) begin
          tag_reg    <= upd_tag;
          target_reg <= upd_target;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign ctr_arr[gi]    = ctr_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
    end
  endgenerate

  // ---------------- misprediction and performance counters
  assign mispredict = upd_valid && (upd_pred_taken != upd_taken);

  sat_perf_counter #(.CNT_W(CNT_W)) u_lookup_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (lookup_hit),
    .count (lookup_count)
  );

  sat_perf_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Two predictors share one stimulus stream: "a" with default parameters,
// "b" with CNT_W=2 and PREDICT_EN=0. A reference model of the table predicts
// both, expectations are queued by the driver and checked by a monitor.
module tb_branch_target_predictor;

  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [ADDR_W-1:0] if_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic              upd_is_jump;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;

  logic              pred_taken_a, pred_taken_b;
  logic [ADDR_W-1:0] pred_target_a, pred_target_b;
  logic              mispredict_a, mispredict_b;
  logic [15:0]       lookup_count_a, mispredict_count_a;
  logic [1:0]        lookup_count_b, mispredict_count_b;

  branch_target_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(16), .PREDICT_EN(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken_a), .pred_target(pred_target_a),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .mispredict(mispredict_a),
    .lookup_count(lookup_count_a), .mispredict_count(mispredict_count_a)
  );

  branch_target_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(2), .PREDICT_EN(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken_b), .pred_target(pred_target_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .mispredict(mispredict_b),
    .lookup_count(lookup_count_b), .mispredict_count(mispredict_count_b)
  );

  // ---------------- scoreboard
  typedef struct {
    logic [31:0] pc;
    logic        pt_a;
    logic [31:0] tgt_a;
    logic        misp;
    logic [15:0] lc_a;
    logic [15:0] mc_a;
    logic [1:0]  lc_b;
    logic [1:0]  mc_b;
  } exp_t;

  exp_t sb_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   txn_count     = 0;

  // ---------------- reference model: table keyed by word address
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          lc_a = 0, mc_a = 0, lc_b = 0, mc_b = 0;

  function automatic int sat_add(input int v, input int inc, input int maxv);
    return (v + inc > maxv) ? maxv : v + inc;
  endfunction

  task automatic step(input logic rst, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic uj, input logic [31:0] utgt, input logic upt);
    exp_t e;
    int   i, ui;
    bit   hit, uhit, misp;
    @(posedge clk);
    #1;
    reset          = rst;
    if_pc          = pc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_is_jump    = uj;
    upd_target     = utgt;
    upd_pred_taken = upt;

    i    = int'((pc / 4) % ENTRIES);
    hit  = m_valid[i] && (m_tag[i] == pc / (4 * ENTRIES));
    misp = uv && (upt != ut);

    e.pc    = pc;
    e.pt_a  = hit && (m_ctr[i] >= 2);
    e.tgt_a = e.pt_a ? m_target[i] : 32'h0;
    e.misp  = misp;
    e.lc_a  = 16'(lc_a);
    e.mc_a  = 16'(mc_a);
    e.lc_b  = 2'(lc_b);
    e.mc_b  = 2'(mc_b);
    sb_q.push_back(e);

    // Model state as seen after this cycle's clock edge.
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 0;
      end
      lc_a = 0; mc_a = 0; lc_b = 0; mc_b = 0;
    end else begin
      lc_a = sat_add(lc_a, int'(hit), 65535);
      lc_b = sat_add(lc_b, int'(hit), 3);
      mc_a = sat_add(mc_a, int'(misp), 65535);
      mc_b = sat_add(mc_b, int'(misp), 3);
      if (uv) begin
        ui   = int'((upc / 4) % ENTRIES);
        uhit = m_valid[ui] && (m_tag[ui] == upc / (4 * ENTRIES));
        if (uhit) begin
          if (uj) begin
            m_ctr[ui] = 3;
            m_target[ui] = utgt;
          end else if (ut) begin
            m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_target[ui] = utgt;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (ut) begin
          m_valid[ui]  = 1'b1;
          m_tag[ui]    = upc / (4 * ENTRIES);
          m_target[ui] = utgt;
          m_ctr[ui]    = uj ? 3 : 2;
        end
      end
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    step(1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks_total++;
    if (act === expv) checks_passed++;
    else $display("FAIL %s txn=%0d: got %0h expected %0h", nm, txn_count, act, expv);
  endtask

  // ---------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pred_taken_a",       64'(pred_taken_a),       64'(e.pt_a));
        chk("pred_target_a",      64'(pred_target_a),      64'(e.tgt_a));
        chk("mispredict_a",       64'(mispredict_a),       64'(e.misp));
        chk("lookup_count_a",     64'(lookup_count_a),     64'(e.lc_a));
        chk("mispredict_count_a", 64'(mispredict_count_a), 64'(e.mc_a));
        chk("pred_taken_b",       64'(pred_taken_b),       64'h0);
        chk("pred_target_b",      64'(pred_target_b),      64'h0);
        chk("mispredict_b",       64'(mispredict_b),       64'(e.misp));
        chk("lookup_count_b",     64'(lookup_count_b),     64'(e.lc_b));
        chk("mispredict_count_b", 64'(mispredict_count_b), 64'(e.mc_b));
        $display("txn %0d pc=%08h pt=%0d tgt=%08h misp=%0d lc=%0d mc=%0d lc_b=%0d mc_b=%0d",
                 txn_count, e.pc, e.pt_a, e.tgt_a, e.misp, e.lc_a, e.mc_a, e.lc_b, e.mc_b);
        txn_count++;
      end
    end
  end

  // ---------------- stimulus
  function automatic logic [31:0] rand_pc();
    return 32'h00400000 + 32'($urandom_range(0, 47) * 4) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] a_pc, j_pc, c_pc, r_pc, upc, utgt;
    logic        rst, uv, ut, uj, upt;
    a_pc = 32'h00400010;
    j_pc = 32'h00400020;
    c_pc = 32'h00400050;
    r_pc = 32'h00400060;

    reset = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_is_jump = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, then lookup on an empty table.
    step(1'b1, a_pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(a_pc);
    // Taken beq allocates (lookup in the same cycle still sees the old state).
    step(1'b0, a_pc, 1'b1, a_pc, 1'b1, 1'b0, 32'h00400040, 1'b0);
    idle(a_pc);
    // Not-taken drops WT to WNT.
    step(1'b0, a_pc, 1'b1, a_pc, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(a_pc);
    // Jump -> ST, then not-taken walks down to SNT and sticks.
    step(1'b0, j_pc, 1'b1, j_pc, 1'b1, 1'b1, 32'h00400100, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, j_pc, 1'b1, j_pc, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(j_pc);
    // Aliasing on index 4 with a different tag replaces the entry.
    step(1'b0, a_pc, 1'b1, a_pc, 1'b1, 1'b0, 32'h00400044, 1'b0);
    step(1'b0, a_pc, 1'b1, c_pc, 1'b1, 1'b0, 32'h00400080, 1'b0);
    idle(a_pc);
    idle(c_pc);
    // An update in a reset cycle is discarded.
    step(1'b1, c_pc, 1'b1, r_pc, 1'b1, 1'b0, 32'h00400200, 1'b1);
    idle(r_pc);
    idle(c_pc);
    // Four mispredicts saturate the 2-bit counter.
    for (int k = 0; k < 4; k++) step(1'b0, r_pc, 1'b1, 32'h00400300, 1'b0, 1'b0, 32'h0, 1'b1);
    // Stall: repeated lookups of a hitting PC.
    step(1'b0, r_pc, 1'b1, r_pc, 1'b1, 1'b0, 32'h00400500, 1'b0);
    for (int k = 0; k < 3; k++) idle(r_pc);

    // Randomized traffic over a small PC pool so entries alias and hit.
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 79) == 0);
      uv   = ($urandom_range(0, 2) != 0);
      uj   = ($urandom_range(0, 5) == 0);
      ut   = uj ? 1'b1 : 1'(($urandom_range(0, 1)));
      upt  = 1'($urandom_range(0, 1));
      upc  = rand_pc();
      utgt = 32'($urandom) & 32'hFFFF_FFFC;
      step(rst, ($urandom_range(0, 3) == 0) ? upc : rand_pc(), uv, upc, ut, uj, utgt, upt);
    end
    idle(32'h0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      checks_total++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipeline. It moves taken-branch and jump redirection from ID into IF. IF looks up the current PC and gets a same-cycle prediction. ID trains the table once the branch or jump resolves, and saturating performance counters track lookups and mispredictions.

## Interface
Parameters:
- ADDR_W, 32: instruction address width.
- ENTRIES, 16: table depth; power of two, 2..256. INDEX_W = log2(ENTRIES).
- CNT_W, 16: width of the performance counters.
- PREDICT_EN, 1: when 0, pred_taken is forced to 0 (static not-taken); the table still trains.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  ADDR_W  PC being fetched this cycle.
- pred_taken  out  1  redirect fetch to pred_target.
- pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0.
- upd_valid  in  1  ID has resolved a branch or jump this cycle.
- upd_pc  in  ADDR_W  address of the resolved instruction.
- upd_taken  in  1  actual direction; 1 for jumps.
- upd_is_jump  in  1  instruction is an unconditional jump.
- upd_target  in  ADDR_W  actual target address.
- upd_pred_taken  in  1  prediction IF made for this instruction, carried through IF/ID.
- mispredict  out  1  upd_valid && (upd_pred_taken != upd_taken); combinational.
- lookup_count  out  CNT_W  saturating count of lookups that hit.
- mispredict_count  out  CNT_W  saturating count of mispredict cycles.

## Operation
- Index = pc[INDEX_W+1:2]; tag = pc[ADDR_W-1:INDEX_W+2]; pc[1:0] is ignored.
- Each entry holds valid, tag, target[ADDR_W] and ctr[1:0]. Counter states: SNT=0, WNT=1, WT=2, ST=3.
- Lookup: hit = valid[idx] && tag[idx]==tag(if_pc).
  - pred_taken = PREDICT_EN && hit && ctr[idx][1].
  - pred_target = target[idx] when pred_taken, else 0.
- Update, when upd_valid=1 and not reset:
  - Hit and jump: ctr becomes ST; target is written.
  - Hit and taken: ctr saturating-increments (3 stays 3); target is overwritten.
  - Hit and not taken: ctr saturating-decrements (0 stays 0); target is unchanged.
  - Miss and taken: the entry is allocated or replaced (direct-mapped). valid=1, tag and target are written, ctr = ST for a jump, else WT.
  - Miss and not taken: no change.
- Perf counters:
  - lookup_count increments on every cycle with hit=1, whether or not PREDICT_EN is set.
  - mispredict_count increments when mispredict=1.
  - Both hold at 2^CNT_W-1.

## Timing
- Lookup is combinational: pred_* depend only on if_pc and the current table state, with zero latency.
- An update is written at the rising edge and becomes visible to a lookup the following cycle.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update contents (no bypass).
- Reset, effective at the next rising edge:
  - All valid bits, all ctr values and both perf counters are cleared.
  - Targets and tags do not need clearing.
  - An update presented in a reset cycle is discarded.
  - After reset, pred_taken=0, pred_target=0 and mispredict follows its inputs.
- Asserting reset mid-run behaves identically; state from before reset must not leak into any prediction.
- A stalled pipeline re-presents the same if_pc, and the lookup repeats (lookup_count increments again on a hit). Suppressing duplicate updates is the caller's job.

## Structure
- Package bp_pkg holds:
  - the counter-state constants SNT, WNT, WT and ST;
  - the functions ctr_inc and ctr_dec (2-bit saturating);
  - the function bp_index/bp_tag split helpers parametrised by ADDR_W and INDEX_W.
- Sub-module sat_perf_counter: a CNT_W-wide saturating incrementer with synchronous reset and an enable input, instantiated twice.
- The table is held in flat register arrays. No RAM macro is used, because the asynchronous read is required.

## Test plan
- Reset then lookup 0x00400010 → pred_taken=0, pred_target=0, lookup_count=0.
- Taken beq update at 0x00400010, target 0x00400040 → next-cycle lookup hits with pred_taken=1, pred_target=0x00400040, ctr=WT. A not-taken update then gives ctr=WNT and pred_taken=0.
- Jump update at 0x00400020 → ctr=ST. Two not-taken updates → ctr=WNT. Further not-taken updates stop at SNT.
- With ENTRIES=16, a taken update at 0x00400010 followed by a taken update at 0x00400050 (same index, different tag) → a lookup of 0x00400010 misses and 0x00400050 hits.
- Same-cycle update and lookup on one index → old prediction this cycle, new prediction the next cycle. An update with reset=1 → no table change.
- CNT_W=2: four mispredicting updates (upd_pred_taken=1, upd_taken=0) → mispredict_count saturates at 3. PREDICT_EN=0 → pred_taken is always 0 while lookup_count still counts hits.
